mdr_mem_if: RTL and testbench

Memory-side front end of the datapath: holds MAR and MDR and drives the bus input BusMuxInMDR.
Runs a request/acknowledge transaction with the RAM for Read and Write control strobes issued by the control unit.
Reports busy/done so the control sequencer stalls until memory completes.
Loads MAR and MDR from BusMuxOut when not busy.

---
 rtl/mdr_mem_if_pkg.sv | 23 ++
 rtl/mdr_mem_if_if.sv | 50 +++++
 rtl/mdr_mem_if_watchdog.sv | 42 ++++
 rtl/mdr_mem_if.sv | 180 ++++++++++++++++++
 tb/tb_mdr_mem_if.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdr_mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdr_mem_if_pkg
// Description : Shared types and default widths for the memory front end
//               (MAR/MDR holder and RAM request/acknowledge sequencer).
// Contents    : mem_state_t   - transaction FSM state encoding
//               c_DATA_WIDTH  - default bus / MDR / RAM data width
//               c_ADDR_WIDTH  - default MAR / RAM address width
// Revision    : 1.0 - initial release
// ============================================================================
package mdr_mem_if_pkg;

  localparam int unsigned c_DATA_WIDTH = 32;
  localparam int unsigned c_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mdr_mem_if_if.sv
`default_nettype none
// ============================================================================
// Module      : mdr_mem_if_if
// Description : Bundle of the shared-bus, control-strobe and RAM handshake
//               signals of the memory front end.
// Modports    : slave  - seen by mdr_mem_if (strobes/bus/RAM response in,
//                        MDR, RAM request and status out)
//               master - seen by the control unit / RAM / testbench
// Signals     : BusMuxOut, MARin, MDRin, Read, Write, BusMuxInMDR, mem_addr,
//               mem_wdata, mem_req, mem_we, mem_rdata, mem_ack, busy, done,
//               mem_err
// Revision    : 1.0 - initial release
// ============================================================================
interface mdr_mem_if_if
  import mdr_mem_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH
);

  logic [DATA_WIDTH-1:0] BusMuxOut;
  logic                  MARin;
  logic                  MDRin;
  logic                  Read;
  logic                  Write;
  logic [DATA_WIDTH-1:0] BusMuxInMDR;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  logic                  busy;
  logic                  done;
  logic                  mem_err;

  modport slave (
    input  BusMuxOut, MARin, MDRin, Read, Write, mem_rdata, mem_ack,
    output BusMuxInMDR, mem_addr, mem_wdata, mem_req, mem_we, busy, done,
           mem_err
  );

  modport master (
    output BusMuxOut, MARin, MDRin, Read, Write, mem_rdata, mem_ack,
    input  BusMuxInMDR, mem_addr, mem_wdata, mem_req, mem_we, busy, done,
           mem_err
  );

endinterface
`default_nettype wire

// File: rtl/mdr_mem_if_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mdr_mem_if_watchdog
// Description : Counts cycles while a memory request is outstanding and
//               flags the cycle in which the TIMEOUT_CYCLES-th request cycle
//               is being sampled without an acknowledge.
// Ports       : clk       - clock
//               rst       - asynchronous active-high reset
//               i_run     - high while a transaction is outstanding
//               o_expired - high in the last allowed request cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mdr_mem_if_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_run,
  output logic      o_expired
);

  localparam int unsigned           c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0]    c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // The count restarts in every idle cycle, so a transaction accepted in a
  // done cycle still begins from zero. Saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != c_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mdr_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : mdr_mem_if
// Description : Memory-side datapath front end. Holds MAR and MDR, drives
//               the MDR onto the bus mux, and runs a request/acknowledge
//               transaction with the RAM for Read/Write strobes while
//               reporting busy/done to the control sequencer.
// Ports       : clock - single clock, rising edge
//               clear - asynchronous active-high reset
//               bus   - mdr_mem_if_if.slave (strobes, shared bus, RAM
//                       handshake, busy/done/mem_err status)
// Options     : MEM_TIMEOUT_EN - when defined, an outstanding request with
//               no acknowledge after TIMEOUT_CYCLES request cycles is
//               aborted with a done pulse and a sticky mem_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mdr_mem_if
  import mdr_mem_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = c_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = c_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  wire logic   clock,
  input  wire logic   clear,
  mdr_mem_if_if.slave bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mdr_mem_if: TIMEOUT_CYCLES must be at least 1");
  end
  if (ADDR_WIDTH > DATA_WIDTH) begin : g_bad_addr_width
    $error("mdr_mem_if: ADDR_WIDTH must not exceed DATA_WIDTH");
  end

  mem_state_t            r_state;
  mem_state_t            w_state_next;
  logic [ADDR_WIDTH-1:0] r_mar;
  logic [ADDR_WIDTH-1:0] w_mar_next;
  logic [DATA_WIDTH-1:0] r_mdr;
  logic [DATA_WIDTH-1:0] w_mdr_next;
  logic                  r_req;
  logic                  w_req_next;
  logic                  r_we;
  logic                  w_we_next;
  logic                  r_done;
  logic                  w_done_next;
  logic                  w_busy;
  logic                  w_timeout;

  assign w_busy = (r_state != IDLE);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers live alongside the state so an async clear abandons
  // the transaction and leaves MDR at zero in the same instant.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_mar  <= '0;
      r_mdr  <= '0;
      r_req  <= 1'b0;
      r_we   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_mar  <= w_mar_next;
      r_mdr  <= w_mdr_next;
      r_req  <= w_req_next;
      r_we   <= w_we_next;
      r_done <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mar_next   = r_mar;
    w_mdr_next   = r_mdr;
    w_req_next   = r_req;
    w_we_next    = r_we;
    w_done_next  = 1'b0;

    case (r_state)
      IDLE: begin
        // Bus loads only while idle so MAR/MDR stay stable for the RAM.
        if (bus.MARin) begin
          w_mar_next = bus.BusMuxOut[ADDR_WIDTH-1:0];
        end
        // A same-cycle Read owns MDR; the bus value would be overwritten.
        if (bus.MDRin && !bus.Read) begin
          w_mdr_next = bus.BusMuxOut;
        end
        // Read has priority; a simultaneous Write is dropped.
        if (bus.Read) begin
          w_state_next = RD_WAIT;
          w_req_next   = 1'b1;
          w_we_next    = 1'b0;
        end else if (bus.Write) begin
          w_state_next = WR_WAIT;
          w_req_next   = 1'b1;
          w_we_next    = 1'b1;
        end
      end

      RD_WAIT: begin
        if (bus.mem_ack) begin
          w_mdr_next   = bus.mem_rdata;
          w_state_next = IDLE;
          w_req_next   = 1'b0;
          w_we_next    = 1'b0;
          w_done_next  = 1'b1;
        end else if (w_timeout) begin
          w_state_next = IDLE;
          w_req_next   = 1'b0;
          w_we_next    = 1'b0;
          w_done_next  = 1'b1;
        end
      end

      WR_WAIT: begin
        if (bus.mem_ack || w_timeout) begin
          w_state_next = IDLE;
          w_req_next   = 1'b0;
          w_we_next    = 1'b0;
          w_done_next  = 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_req_next   = 1'b0;
        w_we_next    = 1'b0;
      end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic r_err;

  mdr_mem_if_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clock),
    .rst       (clear),
    .i_run     (w_busy),
    .o_expired (w_timeout)
  );

  // Ack wins over an expiry in the same cycle, so only a true abort sets
  // the error. Any accepted strobe starts a fresh transaction and clears it.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_err <= 1'b0;
    end else if ((r_state == IDLE) && (bus.Read || bus.Write)) begin
      r_err <= 1'b0;
    end else if (w_busy && w_timeout && !bus.mem_ack) begin
      r_err <= 1'b1;
    end
  end

  assign bus.mem_err = r_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  assign bus.BusMuxInMDR = r_mdr;
  assign bus.mem_addr    = r_mar;
  assign bus.mem_wdata   = r_mdr;
  assign bus.mem_req     = r_req;
  assign bus.mem_we      = r_we;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mdr_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdr_mem_if
// Description : Directed self-checking bench for mdr_mem_if. Expected RAM
//               transactions are queued when a strobe is driven and popped
//               when the done pulse appears.
// Options     : MEM_TIMEOUT_EN - selects the timeout scenario instead of the
//               wait-indefinitely scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdr_mem_if;

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [31:0] data;
  } txn_t;

  logic clock;
  logic clear;
  txn_t sb[$];
  int   n_pass;
  int   n_total;

  mdr_mem_if_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) bus ();

  mdr_mem_if #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (9),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a strobe for one edge, queue the expected transaction, and check
  // the request that must appear right after the accepting edge.
  task automatic issue(input bit rd, input bit wr, input logic [8:0] addr,
                       input logic [31:0] data, input string tag);
    txn_t t;
    t.we   = !rd && wr;
    t.addr = addr;
    t.data = data;
    sb.push_back(t);
    bus.Read  = rd;
    bus.Write = wr;
    tick();
    bus.Read  = 1'b0;
    bus.Write = 1'b0;
    check({tag, "_req"},  {31'd0, bus.mem_req}, 32'd1);
    check({tag, "_we"},   {31'd0, bus.mem_we},  {31'd0, t.we});
    check({tag, "_addr"}, {23'd0, bus.mem_addr}, {23'd0, t.addr});
    check({tag, "_busy"}, {31'd0, bus.busy},    32'd1);
    check({tag, "_done0"}, {31'd0, bus.done},   32'd0);
    if (t.we) check({tag, "_wdata"}, bus.mem_wdata, t.data);
  endtask

  // Hold off the ack for 'waits' cycles, then ack once; leaves the bench in
  // the done cycle and compares against the front of the scoreboard.
  task automatic finish_txn(input int waits, input logic [31:0] rdata,
                            input int exp_busy, input string tag);
    int   busy_n;
    txn_t t;
    busy_n = 0;
    for (int i = 0; i < waits; i++) begin
      if (bus.busy) busy_n++;
      tick();
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    if (bus.busy) busy_n++;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    check({tag, "_done"},  {31'd0, bus.done},    32'd1);
    check({tag, "_busy0"}, {31'd0, bus.busy},    32'd0);
    check({tag, "_req0"},  {31'd0, bus.mem_req}, 32'd0);
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, busy_n, exp_busy);
    check({tag, "_sb_nonempty"}, {31'd0, (sb.size() != 0)}, 32'd1);
    if (sb.size() != 0) begin
      t = sb.pop_front();
      check({tag, "_mdr"}, dut.bus.BusMuxInMDR, t.data);
      check({tag, "_wdata_eq_mdr"}, bus.mem_wdata, t.data);
    end
  endtask

  initial begin
    int n;
    n_pass  = 0;
    n_total = 0;
    clear          = 1'b1;
    bus.BusMuxOut  = 32'h0;
    bus.MARin      = 1'b0;
    bus.MDRin      = 1'b0;
    bus.Read       = 1'b0;
    bus.Write      = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.mem_ack    = 1'b0;
    repeat (2) tick();

    // Reset state.
    check("rst_req",  {31'd0, bus.mem_req}, 32'd0);
    check("rst_we",   {31'd0, bus.mem_we},  32'd0);
    check("rst_done", {31'd0, bus.done},    32'd0);
    check("rst_busy", {31'd0, bus.busy},    32'd0);
    check("rst_err",  {31'd0, bus.mem_err}, 32'd0);
    check("rst_mdr",  bus.BusMuxInMDR,      32'd0);
    check("rst_mar",  {23'd0, bus.mem_addr}, 32'd0);
    clear = 1'b0;

    // Read at 0x1F4, ack after one wait cycle.
    bus.BusMuxOut = 32'h0000_01F4;
    bus.MARin     = 1'b1;
    tick();
    bus.MARin = 1'b0;
    check("t1_mar", {23'd0, bus.mem_addr}, 32'h1F4);
    issue(1'b1, 1'b0, 9'h1F4, 32'hDEAD_BEEF, "t1");
    finish_txn(1, 32'hDEAD_BEEF, 2, "t1");
    tick();
    check("t1_done_once", {31'd0, bus.done}, 32'd0);

    // Write 0xB6 to 0x87, ack after three wait cycles, then a back-to-back read.
    bus.BusMuxOut = 32'h0000_00B6;
    bus.MDRin     = 1'b1;
    tick();
    bus.MDRin     = 1'b0;
    bus.BusMuxOut = 32'h0000_0087;
    bus.MARin     = 1'b1;
    tick();
    bus.MARin = 1'b0;
    check("t2_mdr_load", bus.BusMuxInMDR, 32'hB6);
    issue(1'b0, 1'b1, 9'h087, 32'h0000_00B6, "t2");
    finish_txn(3, 32'hFFFF_FFFF, 4, "t2");
    issue(1'b1, 1'b0, 9'h087, 32'h0000_F00D, "t5");
    finish_txn(0, 32'h0000_F00D, 1, "t5");
    tick();

    // Read and Write together; bus loads during RD_WAIT are ignored.
    issue(1'b1, 1'b1, 9'h087, 32'hCAFE_0001, "t3");
    bus.BusMuxOut = 32'h0000_1234;
    bus.MARin     = 1'b1;
    bus.MDRin     = 1'b1;
    tick();
    bus.MARin = 1'b0;
    bus.MDRin = 1'b0;
    check("t3_mar_hold", {23'd0, bus.mem_addr}, 32'h087);
    check("t3_mdr_hold", bus.BusMuxInMDR,       32'h0000_F00D);
    finish_txn(0, 32'hCAFE_0001, -1, "t3");
    check("t3_mar_after", {23'd0, bus.mem_addr}, 32'h087);
    tick();
    check("t3_no_write", {31'd0, bus.mem_req}, 32'd0);

    // Asynchronous clear in the middle of RD_WAIT.
    issue(1'b1, 1'b0, 9'h087, 32'h0, "t4");
    #2 clear = 1'b1;
    #1;
    check("t4_req_async",  {31'd0, bus.mem_req}, 32'd0);
    check("t4_busy_async", {31'd0, bus.busy},    32'd0);
    check("t4_done_async", {31'd0, bus.done},    32'd0);
    check("t4_mdr_async",  bus.BusMuxInMDR,      32'd0);
    check("t4_mar_async",  {23'd0, bus.mem_addr}, 32'd0);
    #1 clear = 1'b0;
    sb.delete();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.mem_ack   = 1'b0;
    check("t4_idle_ack_mdr",  bus.BusMuxInMDR,   32'd0);
    check("t4_idle_ack_done", {31'd0, bus.done}, 32'd0);
    check("t4_idle_ack_busy", {31'd0, bus.busy}, 32'd0);

    bus.BusMuxOut = 32'h0000_5A5A;
    bus.MDRin     = 1'b1;
    tick();
    bus.MDRin = 1'b0;
`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 16 request cycles with a sticky error.
    issue(1'b1, 1'b0, 9'h000, 32'h0000_5A5A, "t6");
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      tick();
    end
    check("t6_req_cycles", n, 16);
    check("t6_done", {31'd0, bus.done},    32'd1);
    check("t6_err",  {31'd0, bus.mem_err}, 32'd1);
    check("t6_busy", {31'd0, bus.busy},    32'd0);
    check("t6_mdr",  bus.BusMuxInMDR,      32'h0000_5A5A);
    void'(sb.pop_front());
    tick();
    check("t6_err_sticky", {31'd0, bus.mem_err}, 32'd1);
    check("t6_done_once",  {31'd0, bus.done},    32'd0);
    issue(1'b1, 1'b0, 9'h000, 32'h1111_2222, "t7");
    check("t7_err_clr", {31'd0, bus.mem_err}, 32'd0);
    finish_txn(0, 32'h1111_2222, 1, "t7");
`else
    // No ack: the request is held indefinitely and mem_err stays low.
    issue(1'b1, 1'b0, 9'h000, 32'h1111_2222, "t6");
    n = 0;
    while (bus.mem_req && n < 20) begin
      n++;
      tick();
    end
    check("t6_req_held", {31'd0, bus.mem_req}, 32'd1);
    check("t6_busy",     {31'd0, bus.busy},    32'd1);
    check("t6_err",      {31'd0, bus.mem_err}, 32'd0);
    check("t6_mdr",      bus.BusMuxInMDR,      32'h0000_5A5A);
    finish_txn(0, 32'h1111_2222, -1, "t6");
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
